// File: rtl/de10lite_pio_pkg.sv
// de10lite_pio_pkg: board-level constants shared by the DE10-Lite PIO input conditioning
package de10lite_pio_pkg;
  localparam int unsigned SW_WIDTH = 10;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return CLK_HZ / 1000 * ms;
  endfunction
endpackage

// File: rtl/de10lite_debounce_bit.sv
// de10lite_debounce_bit: one switch slice -- 2-flop synchronizer, stability counter, edge pulses
module de10lite_debounce_bit
  import de10lite_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, mismatch;
  logic [CNT_W-1:0] cnt;
  // accept fires on the edge that completes DEBOUNCE_CYCLES consecutive mismatches
  always_comb begin
    mismatch = sync2 ^ stable;
    accept = mismatch && cnt == LAST;
  end
  // synchronize, count the mismatch run, and commit the new level with a one-cycle pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
      cnt <= '0;
      stable <= RESET_VALUE;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt <= (!mismatch || accept) ? '0 : cnt + CNT_W'(1);
      stable <= accept ? sync2 : stable;
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end
endmodule

// File: rtl/de10lite_sw_debounce.sv
// de10lite_sw_debounce: debounced slide-switch levels and edge pulses for the switch PIO
module de10lite_sw_debounce
  import de10lite_pio_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic sw_any_change
);
  logic [WIDTH-1:0] accept;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    de10lite_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_bit (
      .clk(clk),
      .reset_n(reset_n),
      .raw(sw_raw[i]),
      .stable(sw_stable[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i]),
      .accept(accept[i])
    );
  end
  // registered from the same acceptance terms so it lines up with the pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sw_any_change <= 1'b0;
    else sw_any_change <= |accept;
  end
endmodule

// File: tb/tb_de10lite_sw_debounce.sv
// tb_de10lite_sw_debounce: scoreboard bench against a sample-window reference model
module tb_de10lite_sw_debounce;
  localparam int D = 4;
  typedef struct packed {
    logic [9:0] st;
    logic [9:0] ri;
    logic [9:0] fa;
    logic any;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] sw_raw = 10'h3FF;
  logic [9:0] sw_stable, sw_rise, sw_fall;
  logic sw_any_change;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [9:0] pipe[$];
  logic [9:0] hist[$];
  logic [9:0] m_stable;
  exp_t e;
  de10lite_sw_debounce #(
    .WIDTH(10),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE(10'h000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any_change(sw_any_change)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: the two-stage delay line gives what the debouncer sees; a level is
  // accepted once the last D seen samples all disagree with the current stable level
  function automatic void model_reset();
    pipe = '{10'h000, 10'h000};
    hist.delete();
    m_stable = 10'h000;
  endfunction
  task automatic model_edge(input logic [9:0] raw);
    logic [9:0] seen, acc;
    exp_t x;
    seen = pipe.pop_front();
    pipe.push_back(raw);
    hist.push_back(seen);
    if (hist.size() > D) void'(hist.pop_front());
    acc = '0;
    if (hist.size() == D)
      for (int b = 0; b < 10; b++) begin
        acc[b] = 1'b1;
        foreach (hist[k]) if (hist[k][b] == m_stable[b]) acc[b] = 1'b0;
      end
    x.ri = acc & ~m_stable;
    x.fa = acc & m_stable;
    m_stable = m_stable ^ acc;
    x.st = m_stable;
    x.any = |acc;
    sb.push_back(x);
  endtask
  task automatic cycle(input logic [9:0] raw);
    sw_raw = raw;
    @(posedge clk);
    #1;
    model_edge(raw);
  endtask
  task automatic hold(input logic [9:0] raw, input int n);
    for (int i = 0; i < n; i++) cycle(raw);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sw_stable", sw_stable, e.st);
      chk("sw_rise", sw_rise, e.ri);
      chk("sw_fall", sw_fall, e.fa);
      chk("sw_any_change", {9'b0, sw_any_change}, {9'b0, e.any});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    logic [9:0] v;
    model_reset();
    #23;
    chk("reset sw_stable", sw_stable, 10'h000);
    chk("reset pulses", sw_rise | sw_fall, 10'h000);
    #4 reset_n = 1'b1;
    hold(10'h3FF, 5);
    chk("stable before latency", sw_stable, 10'h000);
    cycle(10'h3FF);
    chk("stable at latency", sw_stable, 10'h3FF);
    chk("rise at latency", sw_rise, 10'h3FF);
    chk("any at latency", {9'b0, sw_any_change}, 10'h001);
    cycle(10'h3FF);
    chk("rise one cycle", sw_rise, 10'h000);
    hold(10'h155, 10);
    hold(10'h000, 10);
    hold(10'h001, 3);
    hold(10'h000, 8);
    chk("glitch rejected", sw_stable, 10'h000);
    cycle(10'h020); cycle(10'h000); cycle(10'h020); cycle(10'h000);
    hold(10'h020, 10);
    v = 10'h220;
    hold(v, 2);
    v = v | 10'h004;
    hold(v, 10);
    hold(10'h200, 10);
    hold(10'h208, 4);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset stable", sw_stable, 10'h000);
    chk("async reset pulses", sw_rise | sw_fall, 10'h000);
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    hold(10'h208, 10);
    v = 10'h208;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) v = v ^ (10'h001 << $urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) v = 10'($urandom);
      cycle(v);
    end
    hold(v, 8);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
